// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset datapath: opcodes, functs,
// FSM states, ALU operations and the instruction legality check.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Under opcode 0 only the five supported functs are legal.
    function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:                          return fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/datapath_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, $0 hardwired to zero, asynchronous clear.
module datapath_regfile #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           raddr1,
    input  logic [4:0]           raddr2,
    output logic [BIT_WIDTH-1:0] rdata1,
    output logic [BIT_WIDTH-1:0] rdata2,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [BIT_WIDTH-1:0] wdata
);

    // Entry 0 is not stored at all, so writes to $0 simply have nowhere to land.
    logic [BIT_WIDTH-1:0] rf_reg [1:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            rf_reg[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : rf_reg[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : rf_reg[raddr2];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle MIPS-subset datapath and control (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// sharing one req/ack memory port for instruction and data accesses.
module datapath_mc
    import mips_pkg::*;
#(
    parameter int                    BIT_WIDTH  = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DELAY      = 0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [BIT_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  retire,
    output logic                  trap
);

    // DELAY only shaped simulation timing in older models; register updates here are zero-delay.
    if (ADDR_WIDTH < 16 || ADDR_WIDTH > 32 || BIT_WIDTH < 32 || DELAY < 0) begin : g_param_check
        $error("datapath_mc: unsupported parameter combination");
    end

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_o_reg;
    logic [31:0]           ir_reg;
    logic [BIT_WIDTH-1:0]  a_reg, b_reg, alu_out_reg, mdr_reg;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;

    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign imm    = ir_reg[15:0];
    assign funct  = ir_reg[5:0];
    assign target = ir_reg[25:0];

    logic is_rtype, is_lw, is_sw, is_mem, is_beq, is_j, legal;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_mem   = is_lw || is_sw;
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign legal    = op_legal(opcode, funct);

    logic [BIT_WIDTH-1:0]  rs_val, rt_val, sext_imm, alu_b, alu_result;
    logic [ADDR_WIDTH-1:0] jump_target, branch_off;
    logic [31:0]           branch_off32;
    alu_op_t               alu_op;
    logic                  mem_done, misaligned;

    assign sext_imm     = {{(BIT_WIDTH-16){imm[15]}}, imm};
    assign branch_off32 = {{14{imm[15]}}, imm, 2'b00};
    assign branch_off   = branch_off32[ADDR_WIDTH-1:0];

    if (ADDR_WIDTH > 28) begin : g_jump_hi
        assign jump_target = {pc_reg[ADDR_WIDTH-1:28], target, 2'b00};
    end else begin : g_jump_lo
        assign jump_target = {target[ADDR_WIDTH-3:0], 2'b00};
    end

    datapath_regfile #(.BIT_WIDTH(BIT_WIDTH)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val),
        .we     (state_reg == ST_WB),
        .waddr  (is_rtype ? rd : rt),
        .wdata  (is_lw ? mdr_reg : alu_out_reg)
    );

    always_comb begin
        alu_op = ALU_ADD;
        if (is_rtype) begin
            case (funct)
                F_SUB:   alu_op = ALU_SUB;
                F_AND:   alu_op = ALU_AND;
                F_OR:    alu_op = ALU_OR;
                F_SLT:   alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    assign alu_b = is_rtype ? b_reg : sext_imm;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = a_reg + alu_b;
            ALU_SUB: alu_result = a_reg - alu_b;
            ALU_AND: alu_result = a_reg & alu_b;
            ALU_OR:  alu_result = a_reg | alu_b;
            ALU_SLT: alu_result = {{(BIT_WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    assign misaligned = is_mem && (alu_result[1:0] != 2'b00);

    // Gating with rst lets a reset abandon an in-flight request without waiting for a clock.
    assign mem_req   = !rst && (state_reg == ST_FETCH || state_reg == ST_MEM);
    assign mem_we    = mem_req && (state_reg == ST_MEM) && is_sw;
    assign mem_addr  = (state_reg == ST_MEM) ? ADDR_WIDTH'(alu_out_reg) : pc_reg;
    assign mem_wdata = b_reg;
    assign mem_done  = mem_req && mem_ack;
    assign pc_o      = pc_o_reg;
    assign trap      = (state_reg == ST_TRAP);
    assign retire    = !rst && (((state_reg == ST_DECODE) && legal && (is_j || is_beq)) ||
                                ((state_reg == ST_MEM) && mem_done && is_sw) ||
                                (state_reg == ST_WB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  if (mem_done) state_next = ST_DECODE;
            ST_DECODE: begin
                if (!legal)               state_next = ST_TRAP;
                else if (is_j || is_beq)  state_next = ST_FETCH;
                else                      state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (misaligned)   state_next = ST_TRAP;
                else if (is_mem)  state_next = ST_MEM;
                else              state_next = ST_WB;
            end
            ST_MEM:    if (mem_done) state_next = is_sw ? ST_FETCH : ST_WB;
            ST_WB:     state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            pc_o_reg    <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (mem_done) begin
                        ir_reg   <= 32'(mem_rdata);
                        pc_o_reg <= pc_reg;
                        pc_reg   <= pc_reg + ADDR_WIDTH'(4);
                    end
                end
                ST_DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    // pc already points past the branch, so the offset is relative to pc+4.
                    if (is_j)                              pc_reg <= jump_target;
                    else if (is_beq && (rs_val == rt_val)) pc_reg <= pc_reg + branch_off;
                end
                ST_EXEC:  alu_out_reg <= alu_result;
                ST_MEM:   if (mem_done && is_lw) mdr_reg <= mem_rdata;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: small program in a req/ack memory model with
// separate fetch/data wait counts, hand-computed expectations.
module tb_datapath_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fetch_wait = 0;
    int data_wait = 3;
    int wcnt = 0;
    logic saw_addr6 = 1'b0;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15] = '{default: 32'h0};

    always #5 clk = ~clk;

    datapath_mc #(
        .BIT_WIDTH  (32),
        .ADDR_WIDTH (32),
        .DELAY      (0),
        .RESET_PC   (32'h100)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_o      (pc_o),
        .retire    (retire),
        .trap      (trap)
    );

    // Memory model: instructions live at 0x100 and up, data below; ack after N wait cycles.
    assign mem_rdata = (mem_addr >= 32'h100) ? imem[mem_addr[7:2]] : dmem[mem_addr[5:2]];
    assign mem_ack   = mem_req && (wcnt == ((mem_addr >= 32'h100) ? fetch_wait : data_wait));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else                            wcnt <= wcnt + 1;
        if (mem_req && mem_ack && mem_we && mem_addr < 32'h100) dmem[mem_addr[5:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_req && mem_addr == 32'h6) saw_addr6 <= 1'b1;
        if (mem_req && mem_ack)
            $display("txn t=%0t %s addr=%08h data=%08h", $time, mem_we ? "WR" : "RD",
                     mem_addr, mem_we ? mem_wdata : mem_rdata);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_retire(input string tag, input int max_cyc, output int at_cyc, output logic [31:0] at_pc);
        bit seen = 1'b0;
        at_cyc = 0;
        at_pc  = '0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (retire) begin
                seen   = 1'b1;
                at_cyc = cyc;
                at_pc  = pc_o;
            end
            @(negedge clk);
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (mem_req && mem_addr == addr) seen = 1'b1;
            else                             @(negedge clk);
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_trap(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (trap) seen = 1'b1;
            else      @(negedge clk);
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    // Four req cycles with data_wait=3: request must hold steady, ack lands on the last.
    task automatic check_hold(input string tag, input logic [31:0] addr, input logic we, input logic exp_retire);
        for (int k = 0; k < 4; k++) begin
            check(tag, {mem_req, mem_we, mem_addr}, {1'b1, we, addr});
            if (k == 3) check({tag, "_retire"}, 64'(retire), 64'(exp_retire));
            @(negedge clk);
        end
    endtask

    initial begin
        int          c0, c1, c2, c3;
        logic [31:0] p0, p1, p2, p3;
        int          quiet;

        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0] = 32'h20010005;  // ADDI $1,$0,5
        imem[1] = 32'h2002FFFD;  // ADDI $2,$0,-3
        imem[2] = 32'h00221820;  // ADD  $3,$1,$2
        imem[3] = 32'h0041202A;  // SLT  $4,$2,$1
        imem[4] = 32'hAC030008;  // SW   $3,8($0)
        imem[5] = 32'h8C050008;  // LW   $5,8($0)
        imem[6] = 32'h20000007;  // ADDI $0,$0,7
        imem[7] = 32'h00003020;  // ADD  $6,$0,$0
        imem[8] = 32'h1021FFFF;  // BEQ  $1,$1,-1

        // Reset state and first fetch
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        rst = 1'b0;
        #1;
        check("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100});

        // ALU sequence, zero-wait fetch: one retire every 4 clocks
        wait_retire("r_addi1", 20, c0, p0);
        wait_retire("r_addi2", 20, c1, p1);
        wait_retire("r_add", 20, c2, p2);
        wait_retire("r_slt", 20, c3, p3);
        check("cpi_gap1", 64'(c1 - c0), 64'd4);
        check("cpi_gap2", 64'(c2 - c1), 64'd4);
        check("cpi_gap3", 64'(c3 - c2), 64'd4);
        check("slt_pc", 64'(p3), 64'h10C);
        check("reg1", 64'(u_dut.u_regfile.rf_reg[1]), 64'h5);
        check("reg2", 64'(u_dut.u_regfile.rf_reg[2]), 64'hFFFFFFFD);
        check("reg3", 64'(u_dut.u_regfile.rf_reg[3]), 64'h2);
        check("reg4", 64'(u_dut.u_regfile.rf_reg[4]), 64'h1);

        // SW / LW with three data wait cycles
        wait_req("sw_req", 32'h8, 20);
        check("sw_wdata", 64'(mem_wdata), 64'h2);
        check_hold("sw_hold", 32'h8, 1'b1, 1'b1);
        check("sw_mem", 64'(dmem[2]), 64'h2);
        wait_req("lw_req", 32'h8, 20);
        check_hold("lw_hold", 32'h8, 1'b0, 1'b0);
        wait_retire("r_lw", 10, c0, p0);
        check("lw_pc", 64'(p0), 64'h114);
        check("reg5", 64'(u_dut.u_regfile.rf_reg[5]), 64'h2);

        // $0 writes are discarded
        wait_retire("r_addi0", 20, c0, p0);
        wait_retire("r_add6", 20, c0, p0);
        check("add6_pc", 64'(p0), 64'h11C);
        check("reg6", 64'(u_dut.u_regfile.rf_reg[6]), 64'h0);

        // BEQ to self: retire every 2 clocks at the same pc
        wait_retire("r_beq0", 20, c0, p0);
        wait_retire("r_beq1", 10, c1, p1);
        wait_retire("r_beq2", 10, c2, p2);
        check("beq_pc0", 64'(p0), 64'h120);
        check("beq_pc2", 64'(p2), 64'h120);
        check("beq_gap1", 64'(c1 - c0), 64'd2);
        check("beq_gap2", 64'(c2 - c1), 64'd2);

        // Replace the loop with J 0x40 and make 0x100 a misaligned LW
        imem[8] = 32'h08000040;
        imem[0] = 32'h8C070006;  // LW $7,6($0)
        wait_req("j_fetch", 32'h100, 20);
        check("j_fetch_we", 64'(mem_we), 64'd0);

        wait_trap("misalign_trap", 20);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req || retire || !trap) quiet++;
            @(negedge clk);
        end
        check("trap_quiet", 64'(quiet), 64'd0);
        check("no_mem_addr6", 64'(saw_addr6), 64'd0);

        // Illegal opcode 0x3F
        rst = 1'b1;
        #1;
        check("trap_clr", 64'(trap), 64'd0);
        check("rst_reg1", 64'(u_dut.u_regfile.rf_reg[1]), 64'h0);
        imem[0] = 32'hFC000000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_trap("illegal_trap", 10);

        // Reset during a stalled LW drops the request asynchronously
        rst = 1'b1;
        imem[0] = 32'h8C050008;
        data_wait = 20;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_req("abort_req", 32'h8, 20);
        #2;
        rst = 1'b1;
        #1;
        check("abort_drop", 64'(mem_req), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
